// File: rtl/llpm_mem_pkg.sv
// Shared request-format helpers and arbitration functions for BRAM port sharing.
package llpm_mem_pkg;

    localparam int unsigned MaxReq     = 16;
    localparam int unsigned ReqWrLsb   = 0;
    localparam int unsigned ReqDataLsb = 1;

    // Address field sits above the data field in {addr, data, wr}
    function automatic int unsigned req_addr_lsb(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned req_width(input int unsigned width,
                                              input int unsigned addr_width);
        return width + addr_width + 1;
    endfunction

    function automatic logic [MaxReq-1:0] onehot(input logic [3:0] id);
        logic [MaxReq-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // First set bit of valid searching circularly from ptr over n entries; 0 if none
    function automatic logic [3:0] rr_pick(input logic [MaxReq-1:0] valid,
                                           input logic [3:0]        ptr,
                                           input int unsigned       n);
        logic [3:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = 4'd0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if (k < n) begin
                idx = (32'(ptr) + k) % n;
                if (!found && valid[idx[3:0]]) begin
                    pick  = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester ids awaiting a RAM response.
module arb_tag_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [W-1:0]    mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; all cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Head and status flags
    always_comb begin
        dout  = mem[rd_ptr];
        full  = (count == CntW'(Depth));
        empty = (count == '0);
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port among NumReq valid/bp requesters,
// with an in-order tag FIFO steering responses back to their issuers.
module bram_port_arbiter
    import llpm_mem_pkg::*;
#(
    parameter int unsigned Width          = 8,
    parameter int unsigned AddrWidth      = 8,
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NumReq*(Width+AddrWidth+1)-1:0]     cl_req,
    input  logic [NumReq-1:0]                         cl_req_valid,
    output logic [NumReq-1:0]                         cl_req_bp,
    output logic [NumReq*Width-1:0]                   cl_resp,
    output logic [NumReq-1:0]                         cl_resp_valid,
    input  logic [NumReq-1:0]                         cl_resp_bp,
    output logic [Width+AddrWidth:0]                  mem_req,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_bp,
    input  logic [Width-1:0]                          mem_resp,
    input  logic                                      mem_resp_valid,
    output logic                                      mem_resp_bp
);

    localparam int unsigned ReqW = req_width(Width, AddrWidth);
    localparam int unsigned IdW  = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]    rr_ptr;
    logic [IdW-1:0]    rr_next;
    logic [IdW-1:0]    grant;
    logic [IdW-1:0]    head;
    logic [IdW-1:0]    tgt;
    logic [CntW-1:0]   count;
    logic [MaxReq-1:0] valid_ext;
    logic              full;
    logic              empty;
    logic              blocked;
    logic              req_accept;
    logic              resp_accept;
    logic              bypass;
    logic              push;
    logic              pop;

    // Grant, request/response routing and FIFO control
    always_comb begin
        valid_ext     = MaxReq'(cl_req_valid);
        grant         = IdW'(rr_pick(valid_ext, 4'(rr_ptr), NumReq));
        rr_next       = (grant == IdW'(NumReq - 1)) ? '0 : grant + 1'b1;
        // full blocks new requests regardless of a same-cycle pop
        blocked       = full | reset;
        mem_req_valid = (|cl_req_valid) & ~blocked;
        mem_req       = cl_req[32'(grant)*ReqW +: ReqW];
        req_accept    = mem_req_valid & ~mem_req_bp;
        // With nothing outstanding the response can only belong to this cycle's grant
        tgt           = empty ? grant : head;
        mem_resp_bp   = cl_resp_bp[tgt];
        resp_accept   = mem_resp_valid & ~mem_resp_bp & ~reset;
        bypass        = empty & req_accept & resp_accept;
        push          = req_accept & ~bypass;
        pop           = resp_accept & ~empty;
        cl_resp       = {NumReq{mem_resp}};
        cl_req_bp     = '0;
        cl_resp_valid = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cl_req_bp[i]     = (32'(grant) != i) | mem_req_bp | blocked;
            cl_resp_valid[i] = mem_resp_valid & ~reset & (32'(tgt) == i);
        end
    end

    // Round-robin pointer advances past the requester just served
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           rr_ptr <= '0;
        else if (req_accept) rr_ptr <= rr_next;
    end

    arb_tag_fifo #(
        .W     (IdW),
        .Depth (MaxOutstanding)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (grant),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A response with nothing outstanding and no request in flight is a RAM protocol error
    assert property (@(posedge clk) disable iff (reset)
                     (mem_resp_valid && empty) |-> req_accept);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: contention, write/read, slow RAM,
// response backpressure, async reset and a stalled single requester.
module tb_bram_port_arbiter;

    localparam int unsigned ReqW = 17;

    logic                clk = 1'b0;
    logic                reset;
    logic [4*ReqW-1:0]   cl_req;
    logic [3:0]          cl_req_valid;
    logic [3:0]          cl_req_bp;
    logic [31:0]         cl_resp;
    logic [3:0]          cl_resp_valid;
    logic [3:0]          cl_resp_bp;
    logic [ReqW-1:0]     mem_req;
    logic                mem_req_valid;
    logic                mem_req_bp;
    logic [7:0]          mem_resp;
    logic                mem_resp_valid;
    logic                mem_resp_bp;

    logic                comb_mode;
    logic                man_resp_valid;
    logic [7:0]          man_resp;
    logic [7:0]          ram [256];
    logic [7:0]          comb_data;

    int total = 0;
    int bad   = 0;

    bram_port_arbiter #(
        .Width(8), .AddrWidth(8), .NumReq(4), .MaxOutstanding(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cl_req         (cl_req),
        .cl_req_valid   (cl_req_valid),
        .cl_req_bp      (cl_req_bp),
        .cl_resp        (cl_resp),
        .cl_resp_valid  (cl_resp_valid),
        .cl_resp_bp     (cl_resp_bp),
        .mem_req        (mem_req),
        .mem_req_valid  (mem_req_valid),
        .mem_req_bp     (mem_req_bp),
        .mem_resp       (mem_resp),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_bp    (mem_resp_bp)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read in comb_mode, otherwise responses driven by hand
    assign comb_data      = mem_req[0] ? mem_req[8:1] : ram[mem_req[16:9]];
    assign mem_resp_valid = comb_mode ? (mem_req_valid & ~mem_req_bp) : man_resp_valid;
    assign mem_resp       = comb_mode ? comb_data : man_resp;

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) ram[a] <= 8'(a) ^ 8'h3C;
        end else if (mem_req_valid && !mem_req_bp && mem_req[0]) begin
            ram[mem_req[16:9]] <= mem_req[8:1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ReqW-1:0] mk(input logic [7:0] addr, input logic [7:0] data,
                                           input logic wr);
        return {addr, data, wr};
    endfunction

    task automatic set_req(input int i, input logic [ReqW-1:0] r);
        cl_req[i*ReqW +: ReqW] = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a single read from requester i and check the grant pattern
    task automatic issue(input int i, input logic [7:0] addr, input logic [3:0] exp_bp);
        set_req(i, mk(addr, 8'h00, 1'b0));
        cl_req_valid = 4'(1 << i);
        @(negedge clk);
        chk("issue_bp", 32'(cl_req_bp), 32'(exp_bp));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_bp;
        logic [3:0] exp_oh;
        int         g;

        reset          = 1'b1;
        cl_req         = '0;
        cl_req_valid   = '0;
        cl_resp_bp     = '0;
        mem_req_bp     = 1'b0;
        comb_mode      = 1'b0;
        man_resp_valid = 1'b0;
        man_resp       = '0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_resp_valid", 32'(cl_resp_valid), 32'd0);
        chk("rst_count", 32'(dut.count), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req_bp", 32'(cl_req_bp), 32'hE);
        tick();

        // Contention with a combinational RAM: grants rotate 0,1,2,3,...
        comb_mode = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, mk(8'(16 + i), 8'h00, 1'b0));
        cl_req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            g      = c % 4;
            exp_oh = 4'(1 << g);
            exp_bp = ~exp_oh;
            @(negedge clk);
            chk("cont_bp", 32'(cl_req_bp), 32'(exp_bp));
            chk("cont_resp_valid", 32'(cl_resp_valid), 32'(exp_oh));
            chk("cont_resp_data", 32'(cl_resp[g*8 +: 8]), 32'(8'(16 + g) ^ 8'h3C));
            tick();
        end
        cl_req_valid = '0;
        chk("cont_count", 32'(dut.count), 32'd0);

        // Write then read through the same port
        set_req(0, mk(8'd5, 8'hA5, 1'b1));
        cl_req_valid = 4'b0001;
        @(negedge clk);
        chk("wr_bp", 32'(cl_req_bp), 32'hE);
        chk("wr_resp_valid", 32'(cl_resp_valid), 32'h1);
        tick();
        set_req(2, mk(8'd5, 8'h00, 1'b0));
        cl_req_valid = 4'b0100;
        @(negedge clk);
        chk("rd_resp_valid", 32'(cl_resp_valid), 32'h4);
        chk("rd_resp_data", 32'(cl_resp[23:16]), 32'hA5);
        tick();
        cl_req_valid = '0;

        // Slow RAM: four outstanding reads, fifth blocked until first pop
        comb_mode = 1'b0;
        issue(1, 8'h21, 4'b1101);
        issue(3, 8'h23, 4'b0111);
        issue(0, 8'h20, 4'b1110);
        issue(2, 8'h22, 4'b1011);
        chk("slow_full_count", 32'(dut.count), 32'd4);
        set_req(1, mk(8'h31, 8'h00, 1'b0));
        cl_req_valid   = 4'b0010;
        man_resp_valid = 1'b1;
        man_resp       = 8'h11;
        @(negedge clk);
        chk("full_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("full_bp", 32'(cl_req_bp), 32'hF);
        chk("slow_resp0_oh", 32'(cl_resp_valid), 32'h2);
        chk("slow_resp0_data", 32'(cl_resp[15:8]), 32'h11);
        tick();
        chk("slow_count_pop", 32'(dut.count), 32'd3);
        man_resp = 8'h33;
        @(negedge clk);
        chk("fifth_bp", 32'(cl_req_bp), 32'hD);
        chk("slow_resp1_oh", 32'(cl_resp_valid), 32'h8);
        tick();
        chk("slow_count_pushpop", 32'(dut.count), 32'd3);
        cl_req_valid = '0;
        man_resp = 8'h40;
        @(negedge clk);
        chk("slow_resp2_oh", 32'(cl_resp_valid), 32'h1);
        tick();
        man_resp = 8'h22;
        @(negedge clk);
        chk("slow_resp3_oh", 32'(cl_resp_valid), 32'h4);
        tick();
        man_resp = 8'h31;
        @(negedge clk);
        chk("slow_resp4_oh", 32'(cl_resp_valid), 32'h2);
        tick();
        man_resp_valid = 1'b0;
        chk("slow_count_drain", 32'(dut.count), 32'd0);

        // Response backpressure with requester 1 at the head
        issue(1, 8'h41, 4'b1101);
        issue(0, 8'h40, 4'b1110);
        cl_req_valid   = '0;
        cl_resp_bp     = 4'b0010;
        man_resp_valid = 1'b1;
        man_resp       = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_mem_resp_bp", 32'(mem_resp_bp), 32'd1);
            chk("bp_resp_oh", 32'(cl_resp_valid), 32'h2);
            tick();
            chk("bp_count", 32'(dut.count), 32'd2);
        end
        cl_resp_bp = '0;
        @(negedge clk);
        chk("bp_release", 32'(mem_resp_bp), 32'd0);
        tick();
        chk("bp_count_pop", 32'(dut.count), 32'd1);
        man_resp = 8'h6B;
        @(negedge clk);
        chk("bp_resp_next_oh", 32'(cl_resp_valid), 32'h1);
        tick();
        man_resp_valid = 1'b0;

        // Asynchronous reset with three tags outstanding
        for (int i = 0; i < 4; i++) set_req(i, mk(8'(i), 8'h00, 1'b0));
        cl_req_valid = 4'hF;
        repeat (3) tick();
        chk("pre_rst_count", 32'(dut.count), 32'd3);
        cl_req_valid   = 4'b1010;
        man_resp_valid = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(dut.count), 32'd0);
        chk("arst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("arst_resp_valid", 32'(cl_resp_valid), 32'd0);
        tick();
        man_resp_valid = 1'b0;
        comb_mode      = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_bp", 32'(cl_req_bp), 32'hD);
        chk("post_rst_resp_oh", 32'(cl_resp_valid), 32'h2);
        tick();
        chk("post_rst_rr_ptr", 32'(dut.rr_ptr), 32'd2);
        cl_req_valid = '0;

        // Single requester stalled by the RAM for two cycles
        set_req(3, mk(8'd7, 8'h00, 1'b0));
        cl_req_valid = 4'b1000;
        mem_req_bp   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall_bp", 32'(cl_req_bp), 32'hF);
            chk("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
            tick();
        end
        mem_req_bp = 1'b0;
        @(negedge clk);
        chk("single_bp", 32'(cl_req_bp), 32'h7);
        chk("single_resp_oh", 32'(cl_resp_valid), 32'h8);
        chk("single_resp_data", 32'(cl_resp[31:24]), 32'h3B);
        tick();
        cl_req_valid = '0;
        chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("single_count", 32'(dut.count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
